// File: rtl/ram_capture_ctrl_if.sv
// Signal bundle between the capture controller and its surroundings:
// sample input, dump stream, RAM port and status.
interface ram_capture_ctrl_if #(
    parameter int unsigned RAM_WIDTH = 16,
    parameter int unsigned RAM_DEPTH = 1024
);
    localparam int unsigned AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic                 i_start;
    logic                 i_stop;
    logic                 i_sample_valid;
    logic [RAM_WIDTH-1:0] i_sample_data;
    logic                 i_dump_req;
    logic [RAM_WIDTH-1:0] o_dump_data;
    logic                 o_dump_valid;
    logic                 i_dump_ready;
    logic                 o_dump_last;
    logic [AW-1:0]        o_ram_addr;
    logic [RAM_WIDTH-1:0] o_ram_din;
    logic                 o_ram_we;
    logic                 o_ram_en;
    logic                 o_ram_regce;
    logic [RAM_WIDTH-1:0] i_ram_dout;
    logic [CW-1:0]        o_count;
    logic                 o_busy;
    logic                 o_full;
    logic                 o_overflow;

    // Controller side
    modport master (
        input  i_start, i_stop, i_sample_valid, i_sample_data, i_dump_req,
        input  i_dump_ready, i_ram_dout,
        output o_dump_data, o_dump_valid, o_dump_last,
        output o_ram_addr, o_ram_din, o_ram_we, o_ram_en, o_ram_regce,
        output o_count, o_busy, o_full, o_overflow
    );

    // Environment side (sample source, dump sink, RAM)
    modport slave (
        output i_start, i_stop, i_sample_valid, i_sample_data, i_dump_req,
        output i_dump_ready, i_ram_dout,
        input  o_dump_data, o_dump_valid, o_dump_last,
        input  o_ram_addr, o_ram_din, o_ram_we, o_ram_en, o_ram_regce,
        input  o_count, o_busy, o_full, o_overflow
    );
endinterface

// File: rtl/ram_capture_ctrl.sv
// Captures a burst of samples into an external single-port RAM, then reads
// them back one word at a time over a valid/ready dump stream.
module ram_capture_ctrl #(
    parameter int unsigned RAM_WIDTH = 16,
    parameter int unsigned RAM_DEPTH = 1024,
    parameter int unsigned RD_LAT    = 2
) (
    input  logic               clock,
    input  logic               reset,
    ram_capture_ctrl_if.master bus
);
    localparam int unsigned AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(RAM_DEPTH);
    localparam logic          WAIT_END = 1'(RD_LAT - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] CAPTURE  = 3'd1;
    localparam logic [2:0] DONE     = 3'd2;
    localparam logic [2:0] RD_ISSUE = 3'd3;
    localparam logic [2:0] RD_WAIT  = 3'd4;
    localparam logic [2:0] RD_OUT   = 3'd5;

    logic [2:0]           state_q,      state_next;
    logic [CW-1:0]        count_q,      count_next;
    logic [AW-1:0]        rd_ptr_q,     rd_ptr_next;
    logic                 wait_q,       wait_next;
    logic                 overflow_q,   overflow_next;
    logic [RAM_WIDTH-1:0] dump_data_q,  dump_data_next;
    logic                 dump_valid_q, dump_valid_next;
    logic                 dump_last_q,  dump_last_next;
    logic                 busy_q,       busy_next;
    logic                 full_q,       full_next;

    logic                 ram_en_c;
    logic                 ram_we_c;
    logic [AW-1:0]        ram_addr_c;
    logic [RAM_WIDTH-1:0] ram_din_c;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_next;
    end

    // Next state, datapath next values and the combinational RAM port
    always_comb begin
        state_next      = state_q;
        count_next      = count_q;
        rd_ptr_next     = rd_ptr_q;
        wait_next       = wait_q;
        overflow_next   = overflow_q;
        dump_data_next  = dump_data_q;
        dump_valid_next = dump_valid_q;
        dump_last_next  = dump_last_q;
        ram_en_c        = 1'b0;
        ram_we_c        = 1'b0;
        ram_addr_c      = '0;
        ram_din_c       = '0;

        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    state_next    = CAPTURE;
                    count_next    = '0;
                    overflow_next = 1'b0;
                end
            end
            CAPTURE: begin
                // count_q doubles as the write pointer; the guard keeps it from wrapping
                if (bus.i_sample_valid && (count_q < FULL_CNT)) begin
                    ram_en_c   = 1'b1;
                    ram_we_c   = 1'b1;
                    ram_addr_c = count_q[AW-1:0];
                    ram_din_c  = bus.i_sample_data;
                    count_next = count_q + CW'(1);
                end
                if (bus.i_stop || (count_next == FULL_CNT)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.i_sample_valid) begin
                    overflow_next = 1'b1;
                end
                // A restart wins over a dump request and clears any overflow seen this cycle
                if (bus.i_start) begin
                    state_next    = CAPTURE;
                    count_next    = '0;
                    overflow_next = 1'b0;
                end else if (bus.i_dump_req && (count_q != '0)) begin
                    state_next  = RD_ISSUE;
                    rd_ptr_next = '0;
                end
            end
            RD_ISSUE: begin
                ram_en_c   = 1'b1;
                ram_addr_c = rd_ptr_q;
                wait_next  = 1'b0;
                state_next = RD_WAIT;
            end
            RD_WAIT: begin
                if (wait_q == WAIT_END) begin
                    state_next      = RD_OUT;
                    dump_data_next  = bus.i_ram_dout;
                    dump_valid_next = 1'b1;
                    dump_last_next  = ({1'b0, rd_ptr_q} == (count_q - CW'(1)));
                end else begin
                    wait_next = wait_q + 1'b1;
                end
            end
            RD_OUT: begin
                if (bus.i_dump_ready) begin
                    dump_valid_next = 1'b0;
                    dump_last_next  = 1'b0;
                    if (dump_last_q) begin
                        state_next = DONE;
                    end else begin
                        rd_ptr_next = rd_ptr_q + AW'(1);
                        state_next  = RD_ISSUE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next == CAPTURE)  || (state_next == RD_ISSUE) ||
                    (state_next == RD_WAIT)  || (state_next == RD_OUT);
        full_next = (count_next == FULL_CNT);
    end

    // Datapath and status registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wait_q       <= 1'b0;
            overflow_q   <= 1'b0;
            dump_data_q  <= '0;
            dump_valid_q <= 1'b0;
            dump_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            full_q       <= 1'b0;
        end else begin
            count_q      <= count_next;
            rd_ptr_q     <= rd_ptr_next;
            wait_q       <= wait_next;
            overflow_q   <= overflow_next;
            dump_data_q  <= dump_data_next;
            dump_valid_q <= dump_valid_next;
            dump_last_q  <= dump_last_next;
            busy_q       <= busy_next;
            full_q       <= full_next;
        end
    end

    assign bus.o_ram_en     = ram_en_c;
    assign bus.o_ram_we     = ram_we_c;
    assign bus.o_ram_addr   = ram_addr_c;
    assign bus.o_ram_din    = ram_din_c;
    assign bus.o_ram_regce  = 1'b1;
    assign bus.o_dump_data  = dump_data_q;
    assign bus.o_dump_valid = dump_valid_q;
    assign bus.o_dump_last  = dump_last_q;
    assign bus.o_count      = count_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_full       = full_q;
    assign bus.o_overflow   = overflow_q;
endmodule

// File: doc/ram_capture_ctrl.md
RAM_CAPTURE_CTRL -- requirements
Module: ram_capture_ctrl

Interface
REQ-001 Parameter RAM_WIDTH, default 16, sets the sample and RAM data width.
REQ-002 Parameter RAM_DEPTH, default 1024, sets the number of RAM entries; AW = ceil(log2(RAM_DEPTH)) and CW = AW+1.
REQ-003 Parameter RD_LAT, default 2, sets the RAM read latency: 1 for LOW_LATENCY, 2 for HIGH_PERFORMANCE; no other values are supported.
REQ-004 clock  in  1  single clock; all logic is on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 i_start  in  1  one-cycle pulse that arms a new capture.
REQ-007 i_stop  in  1  one-cycle pulse that ends the capture early.
REQ-008 i_sample_valid  in  1  qualifies i_sample_data.
REQ-009 i_sample_data  in  RAM_WIDTH  sample to store.
REQ-010 i_dump_req  in  1  one-cycle pulse that requests readout of the captured samples.
REQ-011 o_dump_data  out  RAM_WIDTH  readout word.
REQ-012 o_dump_valid  out  1  o_dump_data is valid.
REQ-013 i_dump_ready  in  1  the sink accepts the word.
REQ-014 o_dump_last  out  1  marks the final readout word; qualified by o_dump_valid.
REQ-015 o_ram_addr  out  AW  RAM address_bus.
REQ-016 o_ram_din  out  RAM_WIDTH  RAM data_input.
REQ-017 o_ram_we  out  1  RAM write_enable.
REQ-018 o_ram_en  out  1  RAM enable.
REQ-019 o_ram_regce  out  1  RAM register_enable; constant 1.
REQ-020 i_ram_dout  in  RAM_WIDTH  RAM data_output.
REQ-021 o_count  out  CW  number of samples captured.
REQ-022 o_busy  out  1  high in CAPTURE or any DUMP state.
REQ-023 o_full  out  1  high when o_count equals RAM_DEPTH.
REQ-024 o_overflow  out  1  sticky flag: a sample was offered while in DONE.

Function
REQ-025 The FSM states SHALL be IDLE, CAPTURE, DONE, RD_ISSUE, RD_WAIT and RD_OUT.
REQ-026 IDLE->CAPTURE on i_start; the write pointer and o_count clear to 0 and o_overflow clears.
REQ-027 In CAPTURE, each cycle with i_sample_valid SHALL drive en=1, we=1, addr=o_count[AW-1:0] and din=i_sample_data in that same cycle (combinational), and o_count increments on the edge.
REQ-028 CAPTURE->DONE SHALL occur on the edge where the RAM_DEPTH-th sample is written, or on i_stop.
REQ-029 i_stop together with i_sample_valid SHALL write the sample, count it, then enter DONE.
REQ-030 i_start in CAPTURE or any DUMP state SHALL be ignored; i_start in DONE restarts the capture (as REQ-026), overwriting earlier data.
REQ-031 i_sample_valid outside CAPTURE SHALL NOT write the RAM; in DONE it sets o_overflow.
REQ-032 DONE->RD_ISSUE on i_dump_req when o_count>0, with the read pointer at 0; i_dump_req with o_count=0, or in any other state, is ignored.
REQ-033 RD_ISSUE SHALL drive en=1, we=0, addr=read pointer for exactly one cycle, then go to RD_WAIT.
REQ-034 RD_WAIT SHALL last RD_LAT cycles, so i_ram_dout is sampled exactly RD_LAT cycles after the issue cycle and captured into o_dump_data on entry to RD_OUT.
REQ-035 In RD_OUT, o_dump_valid=1 and o_dump_data is held stable until i_dump_ready=1.
REQ-036 o_dump_last=1 in RD_OUT when read pointer = o_count-1.
REQ-037 A transfer (valid and ready) with last=0 SHALL increment the read pointer and go to RD_ISSUE; a transfer with last=1 SHALL go to DONE, which allows a re-dump.
REQ-038 o_ram_en SHALL be 0 in every cycle with no write or issue; o_ram_we is 0 whenever o_ram_en is 0.
REQ-039 o_count SHALL saturate at RAM_DEPTH; the write address never wraps.

Reset
REQ-040 Reset SHALL force IDLE, and o_count, both pointers, o_dump_data, o_dump_valid, o_dump_last, o_ram_en, o_ram_we, o_ram_addr, o_ram_din, o_overflow, o_busy and o_full to 0, with o_ram_regce=1.
REQ-041 Reset asserted mid-capture or mid-dump SHALL abort at once with no further RAM access; RAM contents are not cleared.

Verification
REQ-042 Use RAM_DEPTH=8 and RD_LAT=2 with the RAM model attached. Start, then 3 valid samples 0xA1,0xA2,0xA3, then stop -> writes at addr 0,1,2; o_count=3; DONE.
REQ-043 Then dump with ready held at 1 -> outputs A1,A2,A3; last only on A3; each word appears 3 cycles after its issue cycle.
REQ-044 Start, then 10 back-to-back samples -> 8 writes; o_full=1 after the 8th sample; samples 9 and 10 are not written and set o_overflow.
REQ-045 Dump with ready low for 5 cycles on word 1 -> data held stable and no new RAM read is issued until the transfer completes.
REQ-046 Assert reset during RD_WAIT -> all outputs take their reset values next; a following start and stop with 1 sample gives o_count=1.
REQ-047 i_stop together with i_sample_valid on the 1st sample, and i_dump_req with o_count=0 -> o_count=1; the zero-count request is ignored and the state stays DONE.
